alu_issue_stage: RTL and testbench

ID/EX issue stage that drives the combinational ALU and captures its result into the EX/MEM output register.
- Accepts decoded ops over a valid/ready handshake.
- Resolves operand forwarding from EX/MEM and MEM/WB at capture.
- Presents rs1/rs2/aluSelect to the ALU and holds them for MULDIV_LAT cycles on mul/div ops.
- Registers the result toward the memory stage with a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_issue_stage_fwd_mux.sv | 30 +++
 rtl/alu_issue_stage.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluSelect code list, issue-stage state encoding
// and the mul/div classifier used by the issue stage and the ALU.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned ALU_SEL_W    = 6;
  localparam int unsigned REG_ADDR_W   = 5;

  // Codes 16..23 form the M-extension group so is_muldiv is a 3-bit compare.
  typedef enum logic [ALU_SEL_W-1:0] {
    ALUSEL_NOP    = 6'd0,
    ALUSEL_ADD    = 6'd1,
    ALUSEL_SUB    = 6'd2,
    ALUSEL_AND    = 6'd3,
    ALUSEL_OR     = 6'd4,
    ALUSEL_XOR    = 6'd5,
    ALUSEL_SLL    = 6'd6,
    ALUSEL_SRL    = 6'd7,
    ALUSEL_SRA    = 6'd8,
    ALUSEL_SLT    = 6'd9,
    ALUSEL_SLTU   = 6'd10,
    ALUSEL_MUL    = 6'd16,
    ALUSEL_MULH   = 6'd17,
    ALUSEL_MULHSU = 6'd18,
    ALUSEL_MULHU  = 6'd19,
    ALUSEL_DIV    = 6'd20,
    ALUSEL_DIVU   = 6'd21,
    ALUSEL_REM    = 6'd22,
    ALUSEL_REMU   = 6'd23
  } alu_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } issue_state_e;

  function automatic logic is_muldiv(input logic [ALU_SEL_W-1:0] sel);
    return sel[ALU_SEL_W-1:3] == 3'b010;
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Per-operand forwarding select: EX/MEM beats MEM/WB beats register file;
// x0 always reads the register-file value.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rf_val,
  input  logic                  exmem_valid,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_data,
  input  logic                  memwb_valid,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_data,
  output logic [XLEN-1:0]       operand_c
);

  always_comb begin
    operand_c = rf_val;
    if (rs_addr != '0) begin
      if (exmem_valid && (exmem_rd == rs_addr)) begin
        operand_c = exmem_data;
      end else if (memwb_valid && (memwb_rd == rs_addr)) begin
        operand_c = memwb_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: captures a decoded op with forwarded operands, drives
// the external ALU (holding mul/div ops) and registers the result for MEM.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned SEL_W      = ALU_SEL_W,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_rs1_val,
  input  logic [XLEN-1:0]       in_rs2_val,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_pc,
  input  logic                  in_use_imm,
  input  logic [SEL_W-1:0]      in_alu_sel,
  input  logic                  fwd_exmem_valid,
  input  logic                  fwd_memwb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_exmem_rd,
  input  logic [REG_ADDR_W-1:0] fwd_memwb_rd,
  input  logic [XLEN-1:0]       fwd_exmem_data,
  input  logic [XLEN-1:0]       fwd_memwb_data,
  output logic [XLEN-1:0]       alu_rs1,
  output logic [XLEN-1:0]       alu_rs2,
  output logic [SEL_W-1:0]      alu_sel,
  input  logic [XLEN-1:0]       alu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [REG_ADDR_W-1:0] out_rd
);

  localparam int unsigned CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_MULDIV = CNT_W'(MULDIV_LAT - 1);

  issue_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]       pc_q, pc_d, imm_q, imm_d;
  logic                  use_pc_q, use_pc_d, use_imm_q, use_imm_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  out_valid_q, out_valid_d;
  logic [XLEN-1:0]       out_result_q, out_result_d;
  logic [REG_ADDR_W-1:0] out_rd_q, out_rd_d;

  logic [XLEN-1:0] fwd_rs1_c, fwd_rs2_c;
  logic            exec_c, done_c, slot_c, accept_c, complete_c;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr    (in_rs1_addr),
    .rf_val     (in_rs1_val),
    .exmem_valid(fwd_exmem_valid),
    .exmem_rd   (fwd_exmem_rd),
    .exmem_data (fwd_exmem_data),
    .memwb_valid(fwd_memwb_valid),
    .memwb_rd   (fwd_memwb_rd),
    .memwb_data (fwd_memwb_data),
    .operand_c  (fwd_rs1_c)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr    (in_rs2_addr),
    .rf_val     (in_rs2_val),
    .exmem_valid(fwd_exmem_valid),
    .exmem_rd   (fwd_exmem_rd),
    .exmem_data (fwd_exmem_data),
    .memwb_valid(fwd_memwb_valid),
    .memwb_rd   (fwd_memwb_rd),
    .memwb_data (fwd_memwb_data),
    .operand_c  (fwd_rs2_c)
  );

  assign exec_c     = (state_q == ST_EXEC);
  assign done_c     = exec_c && (cnt_q == '0);
  assign slot_c     = !out_valid_q || out_ready;
  assign in_ready   = slot_c && (!exec_c || done_c) && !flush;
  assign accept_c   = in_valid && in_ready;
  assign complete_c = done_c && slot_c && !flush;

  // Idle drives a NOP with zero operands so the ALU output is quiet.
  assign alu_rs1 = exec_c ? (use_pc_q ? pc_q : op1_q) : '0;
  assign alu_rs2 = exec_c ? (use_imm_q ? imm_q : op2_q) : '0;
  assign alu_sel = exec_c ? sel_q : SEL_W'(ALUSEL_NOP);

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    use_pc_d     = use_pc_q;
    use_imm_d    = use_imm_q;
    rd_d         = rd_q;
    sel_d        = sel_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;

    if (exec_c && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (complete_c) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_rd_d     = rd_q;
      state_d      = ST_IDLE;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A new op may load in the same cycle the previous one retires.
    if (accept_c) begin
      state_d   = ST_EXEC;
      op1_d     = fwd_rs1_c;
      op2_d     = fwd_rs2_c;
      pc_d      = in_pc;
      imm_d     = in_imm;
      use_pc_d  = in_use_pc;
      use_imm_d = in_use_imm;
      rd_d      = in_rd_addr;
      sel_d     = in_alu_sel;
      cnt_d     = is_muldiv(ALU_SEL_W'(in_alu_sel)) ? CNT_MULDIV : '0;
    end

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      use_pc_q     <= 1'b0;
      use_imm_q    <= 1'b0;
      rd_q         <= '0;
      sel_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      use_pc_q     <= use_pc_d;
      use_imm_q    <= use_imm_d;
      rd_q         <= rd_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU attached.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_val, in_rs2_val;
  logic [4:0]      in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [XLEN-1:0] in_pc, in_imm;
  logic            in_use_pc, in_use_imm;
  logic [5:0]      in_alu_sel;
  logic            fwd_exmem_valid, fwd_memwb_valid;
  logic [4:0]      fwd_exmem_rd, fwd_memwb_rd;
  logic [XLEN-1:0] fwd_exmem_data, fwd_memwb_data;
  logic [XLEN-1:0] alu_rs1, alu_rs2;
  logic [5:0]      alu_sel;
  logic [XLEN-1:0] alu_result;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;

  int total = 0;
  int bad   = 0;

  alu_issue_stage #(.XLEN(XLEN), .SEL_W(6), .MULDIV_LAT(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1_val     (in_rs1_val),
    .in_rs2_val     (in_rs2_val),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rd_addr     (in_rd_addr),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_use_pc      (in_use_pc),
    .in_use_imm     (in_use_imm),
    .in_alu_sel     (in_alu_sel),
    .fwd_exmem_valid(fwd_exmem_valid),
    .fwd_memwb_valid(fwd_memwb_valid),
    .fwd_exmem_rd   (fwd_exmem_rd),
    .fwd_memwb_rd   (fwd_memwb_rd),
    .fwd_exmem_data (fwd_exmem_data),
    .fwd_memwb_data (fwd_memwb_data),
    .alu_rs1        (alu_rs1),
    .alu_rs2        (alu_rs2),
    .alu_sel        (alu_sel),
    .alu_result     (alu_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: only the codes the bench exercises.
  always_comb begin
    case (alu_sel)
      ALUSEL_ADD: alu_result = alu_rs1 + alu_rs2;
      ALUSEL_SUB: alu_result = alu_rs1 - alu_rs2;
      ALUSEL_MUL: alu_result = alu_rs1 * alu_rs2;
      ALUSEL_DIV: alu_result = (alu_rs2 == '0) ? '1 : XLEN'($signed(alu_rs1) / $signed(alu_rs2));
      default:    alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [5:0] sel, input logic [4:0] a1, input logic [XLEN-1:0] v1,
                          input logic [4:0] a2, input logic [XLEN-1:0] v2, input logic [4:0] rd);
    in_alu_sel  = sel;
    in_rs1_addr = a1;
    in_rs1_val  = v1;
    in_rs2_addr = a2;
    in_rs2_val  = v2;
    in_rd_addr  = rd;
    in_use_pc   = 1'b0;
    in_use_imm  = 1'b0;
    in_valid    = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (alu_sel !== 6'd0) begin bad++; $display("FAIL reset_alu_sel got=%0d exp=0", alu_sel); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_result !== 32'd0) begin bad++; $display("FAIL reset_out_result got=%0h exp=0", out_result); end
    total++; if (alu_rs1 !== 32'd0) begin bad++; $display("FAIL reset_alu_rs1 got=%0h exp=0", alu_rs1); end
    #12 reset_n = 1'b1;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    tick();
    drive_op(ALUSEL_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd4);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin bad++; $display("FAIL add_operands got=%0d,%0d exp=5,7", alu_rs1, alu_rs2); end
    total++; if (alu_sel !== 6'(ALUSEL_ADD)) begin bad++; $display("FAIL add_alu_sel got=%0d exp=1", alu_sel); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%0b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd12 || out_rd !== 5'd4) begin bad++; $display("FAIL add_result got=v%0b r%0d rd%0d exp=v1 r12 rd4", out_valid, out_result, out_rd); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_res [3] = '{32'd3, 32'd14, 32'd25};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 3) drive_op(ALUSEL_ADD, 5'd1, 32'(10 * k + 1), 5'd2, 32'(k + 2), 5'(k + 1));
      else in_valid = 1'b0;
      #1;
      if (k < 3) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%0b exp=1", k, in_ready); end
      end
      if (k >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_result !== exp_res[k-2] || out_rd !== 5'(k - 1)) begin
          bad++; $display("FAIL b2b_result k=%0d got=v%0b r%0d rd%0d exp=v1 r%0d rd%0d", k, out_valid, out_result, out_rd, exp_res[k-2], k - 1);
        end
      end
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_muldiv();
    out_ready = 1'b1;
    tick();
    drive_op(ALUSEL_MUL, 5'd1, 32'd6, 5'd2, 32'd7, 5'd9);
    for (int k = 1; k <= 5; k++) begin
      tick();
      in_valid = 1'b0;
      #1;
      if (k <= 3) begin
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL mul_busy k=%0d got=rdy%0b v%0b exp=rdy0 v0", k, in_ready, out_valid); end
        total++; if (alu_sel !== 6'(ALUSEL_MUL)) begin bad++; $display("FAIL mul_hold_sel k=%0d got=%0d exp=16", k, alu_sel); end
      end else if (k == 4) begin
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mul_done got=rdy%0b v%0b exp=rdy1 v0", in_ready, out_valid); end
      end else begin
        total++; if (out_valid !== 1'b1 || out_result !== 32'd42 || out_rd !== 5'd9) begin bad++; $display("FAIL mul_result got=v%0b r%0d rd%0d exp=v1 r42 rd9", out_valid, out_result, out_rd); end
      end
    end
    tick();
  endtask

  task automatic test_forwarding();
    logic            exv  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]      exrd [5] = '{5'd3, 5'd3, 5'd5, 5'd0, 5'd3};
    logic            mwv  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0]      mwrd [5] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd3};
    logic [4:0]      ra1  [5] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd3};
    logic [4:0]      ra2  [5] = '{5'd3, 5'd3, 5'd5, 5'd0, 5'd3};
    logic            upc  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic            uimm [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [XLEN-1:0] e1   [5] = '{32'h10, 32'h20, 32'h20, 32'h100, 32'h1000};
    logic [XLEN-1:0] e2   [5] = '{32'h10, 32'h20, 32'h10, 32'h200, 32'h24};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      drive_op(ALUSEL_ADD, ra1[i], 32'h100, ra2[i], 32'h200, 5'd8);
      in_use_pc       = upc[i];
      in_use_imm      = uimm[i];
      in_pc           = 32'h1000;
      in_imm          = 32'h24;
      fwd_exmem_valid = exv[i];
      fwd_exmem_rd    = exrd[i];
      fwd_exmem_data  = 32'h10;
      fwd_memwb_valid = mwv[i];
      fwd_memwb_rd    = mwrd[i];
      fwd_memwb_data  = 32'h20;
      tick();
      in_valid        = 1'b0;
      fwd_exmem_valid = 1'b0;
      fwd_memwb_valid = 1'b0;
      #1;
      total++; if (alu_rs1 !== e1[i] || alu_rs2 !== e2[i]) begin bad++; $display("FAIL fwd_operands case=%0d got=%0h,%0h exp=%0h,%0h", i, alu_rs1, alu_rs2, e1[i], e2[i]); end
      tick();
      total++; if (out_valid !== 1'b1 || out_result !== e1[i] + e2[i]) begin bad++; $display("FAIL fwd_result case=%0d got=v%0b %0h exp=v1 %0h", i, out_valid, out_result, e1[i] + e2[i]); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    tick();
    drive_op(ALUSEL_ADD, 5'd1, 32'd1, 5'd2, 32'd2, 5'd1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_a got=%0b exp=1", in_ready); end
    tick();
    drive_op(ALUSEL_ADD, 5'd1, 32'd3, 5'd2, 32'd4, 5'd2);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept_b got=%0b exp=1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b1 || out_result !== 32'd3 || out_rd !== 5'd1) begin bad++; $display("FAIL bp_hold k=%0d got=v%0b r%0d rd%0d exp=v1 r3 rd1", k, out_valid, out_result, out_rd); end
      total++; if (in_ready !== 1'b0 || alu_rs1 !== 32'd3 || alu_rs2 !== 32'd4) begin bad++; $display("FAIL bp_stall k=%0d got=rdy%0b %0d,%0d exp=rdy0 3,4", k, in_ready, alu_rs1, alu_rs2); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd7 || out_rd !== 5'd2) begin bad++; $display("FAIL bp_second got=v%0b r%0d rd%0d exp=v1 r7 rd2", out_valid, out_result, out_rd); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    tick();
    drive_op(ALUSEL_MUL, 5'd1, 32'd3, 5'd2, 32'd5, 5'd5);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    tick();
    flush = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || alu_sel !== 6'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_idle got=v%0b sel%0d rdy%0b exp=v0 sel0 rdy1", out_valid, alu_sel, in_ready); end
    drive_op(ALUSEL_ADD, 5'd1, 32'd2, 5'd2, 32'd2, 5'd6);
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (alu_sel !== 6'(ALUSEL_ADD) || out_valid !== 1'b0) begin bad++; $display("FAIL flush_next_issue got=sel%0d v%0b exp=sel1 v0", alu_sel, out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd4 || out_rd !== 5'd6) begin bad++; $display("FAIL flush_next_result got=v%0b r%0d rd%0d exp=v1 r4 rd6", out_valid, out_result, out_rd); end
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost k=%0d got=v%0b r%0d exp=v0", k, out_valid, out_result); end
    end
  endtask

  task automatic test_reset_mid_div();
    out_ready = 1'b1;
    tick();
    drive_op(ALUSEL_DIV, 5'd1, 32'd100, 5'd2, 32'd7, 5'd7);
    tick();
    in_valid = 1'b0;
    tick();
    total++; if (alu_sel !== 6'(ALUSEL_DIV)) begin bad++; $display("FAIL div_live got=%0d exp=20", alu_sel); end
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || alu_sel !== 6'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_div got=v%0b sel%0d rdy%0b exp=v0 sel0 rdy1", out_valid, alu_sel, in_ready); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready_rdy1 got=%0b exp=1", in_ready); end
    tick();
    #3 reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (out_valid !== 1'b0 || alu_sel !== 6'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_abandon k=%0d got=v%0b sel%0d rdy%0b exp=v0 sel0 rdy1", k, out_valid, alu_sel, in_ready); end
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    flush           = 1'b0;
    in_valid        = 1'b0;
    in_rs1_val      = '0;
    in_rs2_val      = '0;
    in_rs1_addr     = '0;
    in_rs2_addr     = '0;
    in_rd_addr      = '0;
    in_pc           = '0;
    in_imm          = '0;
    in_use_pc       = 1'b0;
    in_use_imm      = 1'b0;
    in_alu_sel      = '0;
    fwd_exmem_valid = 1'b0;
    fwd_memwb_valid = 1'b0;
    fwd_exmem_rd    = '0;
    fwd_memwb_rd    = '0;
    fwd_exmem_data  = '0;
    fwd_memwb_data  = '0;
    out_ready       = 1'b0;

    test_reset();
    test_add();
    test_back_to_back();
    test_muldiv();
    test_forwarding();
    test_backpressure();
    test_flush();
    test_reset_mid_div();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
